// File: rtl/edlo_pkg.sv
// Shared constants for the EDLO program sequencer.
// Contents: opcodes, FSM state codes and instruction field positions.
package edlo_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_JNZ  = 4'hD;
    localparam logic [3:0] OP_LDA  = 4'hE;
    localparam logic [3:0] OP_STA  = 4'hF;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_FETCH  = 4'd1;
    localparam state_t ST_DECODE = 4'd2;
    localparam state_t ST_OPADDR = 4'd3;
    localparam state_t ST_OPDATA = 4'd4;
    localparam state_t ST_EXEC   = 4'd5;
    localparam state_t ST_WB     = 4'd6;
    localparam state_t ST_STORE  = 4'd7;
    localparam state_t ST_HALTED = 4'd8;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int ARG_MSB = 3;
    localparam int ARG_LSB = 0;

    function automatic logic [3:0] op_of(input logic [7:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [3:0] arg_of(input logic [7:0] instr);
        return instr[ARG_MSB:ARG_LSB];
    endfunction

endpackage

// File: rtl/edlo_if.sv
// Host, RAM and ALU signal bundle of the EDLO sequencer.
// The slave modport is the sequencer; master is everything around it.
interface edlo_if #(
    parameter int ADDR_BITS = 4
) ();
    logic                 start;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [ADDR_BITS-1:0] ld_addr;
    logic [7:0]           ld_data;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;
    logic [3:0]           alu_op;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [7:0]           alu_ret;
    logic [7:0]           acc;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, ld_valid, ld_addr, ld_data, mem_rdata, alu_ret,
        input  ld_ready, mem_addr, mem_we, mem_wdata, alu_op, alu_a, alu_b,
               acc, busy, done, err
    );

    modport slave (
        input  start, ld_valid, ld_addr, ld_data, mem_rdata, alu_ret,
        output ld_ready, mem_addr, mem_we, mem_wdata, alu_op, alu_a, alu_b,
               acc, busy, done, err
    );
endinterface

// File: rtl/edlo_sequencer.sv
// EDLO program sequencer: fetch/decode/execute over the shared RAM port,
// with host loads accepted only while idle or halted.
module edlo_sequencer
    import edlo_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int ALU_LAT   = 1,
    parameter int MAX_STEPS = 255
) (
    input  logic  clk,
    input  logic  rst_n,
    edlo_if.slave bus
);

    localparam int STEP_W = ($clog2(MAX_STEPS + 1) < 1) ? 1 : $clog2(MAX_STEPS + 1);
    localparam int LAT_W  = ($clog2(ALU_LAT + 1) < 1) ? 1 : $clog2(ALU_LAT + 1);

    state_t               state_r;
    logic [ADDR_BITS-1:0] pc_r;
    logic [7:0]           acc_r;
    logic [7:0]           ir_r;
    logic [7:0]           opnd_r;
    logic [STEP_W-1:0]    step_r;
    logic [LAT_W-1:0]     lat_r;
    logic                 err_r;

    logic                 idle_s;
    logic                 ld_ready_s;
    logic                 ld_accept_s;
    logic [ADDR_BITS-1:0] rd_arg_s;
    logic [ADDR_BITS-1:0] ir_arg_s;

    // The 4-bit argument field is zero-extended or truncated to the RAM width.
    function automatic logic [ADDR_BITS-1:0] to_addr(input logic [3:0] a);
        logic [ADDR_BITS+3:0] w;
        w = {{ADDR_BITS{1'b0}}, a};
        return w[ADDR_BITS-1:0];
    endfunction

    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_HALTED);
    assign ld_ready_s  = rst_n && idle_s && !bus.start;
    assign ld_accept_s = ld_ready_s && bus.ld_valid;
    assign rd_arg_s    = to_addr(arg_of(bus.mem_rdata));
    assign ir_arg_s    = to_addr(arg_of(ir_r));

    assign bus.ld_ready = ld_ready_s;
    assign bus.acc      = acc_r;
    assign bus.busy     = !idle_s;
    assign bus.done     = (state_r == ST_HALTED);
    assign bus.err      = err_r;

    // RAM port mux; a write is never issued while reset is asserted.
    always_comb begin
        bus.mem_addr  = {ADDR_BITS{1'b0}};
        bus.mem_wdata = 8'h00;
        bus.mem_we    = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                if (ld_accept_s) begin
                    bus.mem_addr  = bus.ld_addr;
                    bus.mem_wdata = bus.ld_data;
                    bus.mem_we    = 1'b1;
                end else begin
                    bus.mem_we    = 1'b0;
                end
            end
            ST_FETCH:  bus.mem_addr = pc_r;
            ST_OPADDR: bus.mem_addr = ir_arg_s;
            ST_STORE: begin
                bus.mem_addr  = ir_arg_s;
                bus.mem_wdata = acc_r;
                bus.mem_we    = rst_n;
            end
            default:   bus.mem_addr = {ADDR_BITS{1'b0}};
        endcase
    end

    // ALU operands are held only during EXEC and are zero elsewhere.
    always_comb begin
        if (state_r == ST_EXEC) begin
            bus.alu_op = op_of(ir_r);
            bus.alu_a  = acc_r;
            bus.alu_b  = opnd_r;
        end else begin
            bus.alu_op = 4'h0;
            bus.alu_a  = 8'h00;
            bus.alu_b  = 8'h00;
        end
    end

    // Sequencer state, program counter, accumulator and budget counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {ADDR_BITS{1'b0}};
            acc_r   <= 8'h00;
            ir_r    <= 8'h00;
            opnd_r  <= 8'h00;
            step_r  <= {STEP_W{1'b0}};
            lat_r   <= {LAT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (bus.start) begin
                        state_r <= ST_FETCH;
                        pc_r    <= {ADDR_BITS{1'b0}};
                        step_r  <= {STEP_W{1'b0}};
                        err_r   <= 1'b0;
                    end
                end
                ST_FETCH: state_r <= ST_DECODE;
                ST_DECODE: begin
                    ir_r   <= bus.mem_rdata;
                    step_r <= step_r + STEP_W'(1);
                    if (step_r == STEP_W'(MAX_STEPS)) begin
                        state_r <= ST_HALTED;
                        err_r   <= 1'b1;
                    end else begin
                        case (op_of(bus.mem_rdata))
                            OP_HALT: state_r <= ST_HALTED;
                            OP_JNZ: begin
                                pc_r    <= (acc_r != 8'h00) ? rd_arg_s : pc_r + ADDR_BITS'(1);
                                state_r <= ST_FETCH;
                            end
                            OP_STA:  state_r <= ST_STORE;
                            default: state_r <= ST_OPADDR;
                        endcase
                    end
                end
                ST_OPADDR: state_r <= ST_OPDATA;
                ST_OPDATA: begin
                    opnd_r <= bus.mem_rdata;
                    if (op_of(ir_r) == OP_LDA) begin
                        acc_r   <= bus.mem_rdata;
                        pc_r    <= pc_r + ADDR_BITS'(1);
                        state_r <= ST_FETCH;
                    end else begin
                        lat_r   <= LAT_W'(ALU_LAT - 1);
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (lat_r == LAT_W'(0)) begin
                        state_r <= ST_WB;
                    end else begin
                        lat_r <= lat_r - LAT_W'(1);
                    end
                end
                ST_WB: begin
                    acc_r   <= bus.alu_ret;
                    pc_r    <= pc_r + ADDR_BITS'(1);
                    state_r <= ST_FETCH;
                end
                ST_STORE: begin
                    pc_r    <= pc_r + ADDR_BITS'(1);
                    state_r <= ST_FETCH;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edlo_sequencer.sv
// Directed bench for edlo_sequencer: bench-side RAM and one-cycle ALU models,
// main instance with the full step budget and a second one with a budget of 8.
module tb_edlo_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    edlo_if #(.ADDR_BITS(4)) if0 ();
    edlo_if #(.ADDR_BITS(4)) if1 ();

    edlo_sequencer #(.ADDR_BITS(4), .ALU_LAT(1), .MAX_STEPS(255)) dut (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    edlo_sequencer #(.ADDR_BITS(4), .ALU_LAT(1), .MAX_STEPS(8)) dut_wd (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
        if0.mem_rdata <= mem0[if0.mem_addr];
        if0.alu_ret   <= alu_model(if0.alu_op, if0.alu_a, if0.alu_b);
    end

    always @(posedge clk) begin
        if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
        if1.mem_rdata <= mem1[if1.mem_addr];
        if1.alu_ret   <= alu_model(if1.alu_op, if1.alu_a, if1.alu_b);
    end

    task automatic do_load(input int which, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        if (which == 0) begin
            if0.ld_valid = 1'b1; if0.ld_addr = a; if0.ld_data = d;
        end else begin
            if1.ld_valid = 1'b1; if1.ld_addr = a; if1.ld_data = d;
        end
        @(negedge clk);
        if0.ld_valid = 1'b0;
        if1.ld_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge right after the start edge (cycle 0 = FETCH).
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) if0.start = 1'b1; else if1.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit, output int n);
        n = 0;
        while (((which == 0) ? !if0.done : !if1.done) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if0.ld_valid = 1'b1; if0.ld_addr = 4'd3; if0.ld_data = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (if0.ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", if0.ld_ready); end
        checks++; if (if0.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", if0.mem_we); end
        checks++; if ({if0.busy, if0.done, if0.err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {if0.busy, if0.done, if0.err}); end
        checks++; if (if0.acc !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", if0.acc); end
        checks++; if ({if0.alu_op, if0.alu_a, if0.alu_b} !== 20'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {if0.alu_op, if0.alu_a, if0.alu_b}); end
        if0.ld_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if0.ld_ready !== 1'b1) begin failures++; $display("FAIL idle_ld_ready got=%b exp=1", if0.ld_ready); end
    endtask

    task automatic test_load_run;
        int n;
        do_load(0, 4'd0, 8'hE8); do_load(0, 4'd1, 8'h19); do_load(0, 4'd2, 8'hFA);
        do_load(0, 4'd3, 8'h00); do_load(0, 4'd8, 8'h03); do_load(0, 4'd9, 8'h04);
        do_load(0, 4'd10, 8'h00);
        checks++; if (mem0[8] !== 8'h03) begin failures++; $display("FAIL load_write got=%h exp=03", mem0[8]); end
        pulse_start(0);
        checks++; if (if0.busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%b exp=1", if0.busy); end
        wait_done(0, 100, n);
        checks++; if (n !== 15) begin failures++; $display("FAIL run_cycles got=%0d exp=15", n); end
        checks++; if (if0.acc !== 8'h07) begin failures++; $display("FAIL run_acc got=%h exp=07", if0.acc); end
        checks++; if (mem0[10] !== 8'h07) begin failures++; $display("FAIL run_sta got=%h exp=07", mem0[10]); end
        checks++; if ({if0.done, if0.err, if0.busy} !== 3'b100) begin failures++; $display("FAIL run_flags got=%b exp=100", {if0.done, if0.err, if0.busy}); end
    endtask

    task automatic test_jnz_loop;
        int n;
        do_load(0, 4'd0, 8'hE8); do_load(0, 4'd1, 8'h29); do_load(0, 4'd2, 8'hD1);
        do_load(0, 4'd3, 8'h00); do_load(0, 4'd8, 8'h03); do_load(0, 4'd9, 8'h01);
        pulse_start(0);
        wait_done(0, 200, n);
        checks++; if (n !== 30) begin failures++; $display("FAIL jnz_cycles got=%0d exp=30", n); end
        checks++; if (if0.acc !== 8'h00) begin failures++; $display("FAIL jnz_acc got=%h exp=00", if0.acc); end
        checks++; if ({if0.done, if0.err} !== 2'b10) begin failures++; $display("FAIL jnz_flags got=%b exp=10", {if0.done, if0.err}); end
    endtask

    task automatic test_arbitration;
        int n;
        do_load(0, 4'd12, 8'h00);
        @(negedge clk);
        if0.start = 1'b1; if0.ld_valid = 1'b1; if0.ld_addr = 4'd12; if0.ld_data = 8'h5A;
        #1;
        checks++; if (if0.ld_ready !== 1'b0) begin failures++; $display("FAIL arb_ld_ready got=%b exp=0", if0.ld_ready); end
        checks++; if (if0.mem_we !== 1'b0) begin failures++; $display("FAIL arb_mem_we got=%b exp=0", if0.mem_we); end
        @(negedge clk);
        if0.start = 1'b0;
        checks++; if (if0.busy !== 1'b1) begin failures++; $display("FAIL arb_busy got=%b exp=1", if0.busy); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (if0.ld_ready !== 1'b0) begin failures++; $display("FAIL busy_ld_ready cyc=%0d got=%b exp=0", i, if0.ld_ready); end
            @(negedge clk);
        end
        if0.ld_valid = 1'b0;
        wait_done(0, 200, n);
        checks++; if (if0.done !== 1'b1) begin failures++; $display("FAIL arb_done got=%b exp=1", if0.done); end
        checks++; if (mem0[12] !== 8'h00) begin failures++; $display("FAIL arb_ram got=%h exp=00", mem0[12]); end
    endtask

    task automatic test_reset_store;
        do_load(0, 4'd0, 8'hE8); do_load(0, 4'd1, 8'hFB); do_load(0, 4'd2, 8'h00);
        do_load(0, 4'd8, 8'h03); do_load(0, 4'd11, 8'h00);
        pulse_start(0);
        repeat (6) @(negedge clk);
        checks++; if ({if0.mem_we, if0.mem_addr} !== 5'b1_1011) begin failures++; $display("FAIL store_cycle got=%b exp=11011", {if0.mem_we, if0.mem_addr}); end
        rst_n = 1'b0;
        #1;
        checks++; if (if0.mem_we !== 1'b0) begin failures++; $display("FAIL rst_store_we got=%b exp=0", if0.mem_we); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if ({if0.busy, if0.done} !== 2'b00) begin failures++; $display("FAIL rst_store_idle got=%b exp=00", {if0.busy, if0.done}); end
        checks++; if (if0.acc !== 8'h00) begin failures++; $display("FAIL rst_store_acc got=%h exp=00", if0.acc); end
        @(negedge clk);
        checks++; if (mem0[11] !== 8'h00) begin failures++; $display("FAIL rst_store_ram got=%h exp=00", mem0[11]); end
    endtask

    task automatic test_pc_wrap;
        int n;
        for (int i = 0; i < 16; i++) do_load(0, 4'(i), 8'hE0 | 8'(i));
        pulse_start(0);
        repeat (60) @(negedge clk);
        checks++; if (if0.mem_addr !== 4'd15) begin failures++; $display("FAIL wrap_pc15 got=%0d exp=15", if0.mem_addr); end
        repeat (4) @(negedge clk);
        checks++; if ({if0.busy, if0.mem_addr} !== 5'b1_0000) begin failures++; $display("FAIL wrap_pc0 got=%b exp=10000", {if0.busy, if0.mem_addr}); end
        wait_done(0, 2000, n);
        checks++; if (n !== 958) begin failures++; $display("FAIL wrap_cycles got=%0d exp=958", n); end
        checks++; if ({if0.done, if0.err} !== 2'b11) begin failures++; $display("FAIL wrap_err got=%b exp=11", {if0.done, if0.err}); end
        checks++; if (if0.acc !== 8'hEE) begin failures++; $display("FAIL wrap_acc got=%h exp=ee", if0.acc); end
    endtask

    task automatic test_watchdog;
        int n;
        do_load(1, 4'd0, 8'hE1); do_load(1, 4'd1, 8'h05);
        pulse_start(1);
        wait_done(1, 100, n);
        checks++; if ({if1.acc, if1.err} !== 9'b0000_0101_0) begin failures++; $display("FAIL wd_setup got=%h exp=0a", {if1.acc, if1.err}); end
        do_load(1, 4'd0, 8'hD0);
        pulse_start(1);
        wait_done(1, 100, n);
        checks++; if (n !== 18) begin failures++; $display("FAIL wd_cycles got=%0d exp=18", n); end
        checks++; if ({if1.done, if1.err} !== 2'b11) begin failures++; $display("FAIL wd_err got=%b exp=11", {if1.done, if1.err}); end
        pulse_start(1);
        checks++; if ({if1.busy, if1.err} !== 2'b10) begin failures++; $display("FAIL wd_restart got=%b exp=10", {if1.busy, if1.err}); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        if0.start = 1'b0; if0.ld_valid = 1'b0; if0.ld_addr = 4'd0; if0.ld_data = 8'h00;
        if1.start = 1'b0; if1.ld_valid = 1'b0; if1.ld_addr = 4'd0; if1.ld_data = 8'h00;
        test_reset();
        test_load_run();
        test_jnz_loop();
        test_arbitration();
        test_reset_store();
        test_pc_wrap();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
